// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone B4 bus bundle shared by the frame reader and its memory slave
//
// Signals: cyc stb we adr sel cti bte dat_ms (master -> slave),
//          dat_sm ack err rty (slave -> master).
// Modports: master (drives the request side), slave (drives the response side).
`timescale 1ns/1ps
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_frame_reader.sv
// rtl/wb_frame_reader.sv - Wishbone burst reader looping over a frame buffer into a show-ahead FIFO
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   enable     in   allow new bursts to start
//   wb_m       wshb_if.master  incrementing-burst read master (err/rty ignored)
//   out_data   out  FIFO head word (0 while empty)
//   out_sof    out  head word is frame word 0
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes the head when out_valid & out_ready
`timescale 1ns/1ps
module wb_frame_reader #(
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned NB_WORDS   = 2048,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    wshb_if.master       wb_m,
    output logic [31:0]  out_data,
    output logic         out_sof,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned IW = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [IW-1:0]   word_idx;
    logic [BW-1:0]   beat;

    logic [32:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [32:0]     head;

    logic            push;
    logic            pop;
    logic            last_beat;
    logic            can_start;
    logic [IW-1:0]   next_idx;
    logic [31:0]     next_adr;

    // Read-only master: the write-side fields never change.
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'b1111;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = 32'h0;

    assign push      = (state == BURST) && wb_m.cyc && wb_m.stb && wb_m.ack;
    assign pop       = out_valid && out_ready;
    assign last_beat = (beat == BW'(BURST_LEN - 1));

    // Reserve room for a whole burst before starting it, so an in-flight
    // burst can always land without checking for a full FIFO.
    assign can_start = (fifo_count <= CW'(FIFO_DEPTH - BURST_LEN));

    assign next_idx  = (word_idx == IW'(NB_WORDS - 1)) ? '0 : word_idx + IW'(1);
    assign next_adr  = BASE_ADR + (32'(next_idx) << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_m.cyc <= 1'b0;
            wb_m.stb <= 1'b0;
            wb_m.cti <= 3'b000;
            wb_m.adr <= BASE_ADR;
            word_idx <= '0;
            beat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && can_start) begin
                        state    <= BURST;
                        beat     <= '0;
                        wb_m.cyc <= 1'b1;
                        wb_m.stb <= 1'b1;
                        wb_m.cti <= (BURST_LEN == 1) ? 3'b111 : 3'b010;
                    end
                end
                BURST: begin
                    // Without ack the request fields hold, which covers wait states.
                    if (wb_m.ack) begin
                        word_idx <= next_idx;
                        wb_m.adr <= next_adr;
                        beat     <= beat + BW'(1);
                        if (last_beat) begin
                            state    <= IDLE;
                            wb_m.cyc <= 1'b0;
                            wb_m.stb <= 1'b0;
                            wb_m.cti <= 3'b000;
                        end else begin
                            // Look one beat ahead: the upcoming beat is the last one.
                            wb_m.cti <= (beat == BW'(BURST_LEN - 2)) ? 3'b111 : 3'b010;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    wb_m.cyc <= 1'b0;
                    wb_m.stb <= 1'b0;
                    wb_m.cti <= 3'b000;
                end
            endcase
        end
    end

    // Storage array carries no reset; emptiness is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {(word_idx == '0), wb_m.dat_sm};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head is gated by valid so stale array contents never leak out after reset.
    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? head[31:0] : 32'h0;
    assign out_sof   = out_valid && head[32];

endmodule

// File: tb/tb_wb_frame_reader.sv
// tb/tb_wb_frame_reader.sv - self-checking bench for wb_frame_reader
`timescale 1ns/1ps
module tb_wb_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sof;
    logic        out_valid;

    wshb_if wb ();

    wb_frame_reader #(
        .BASE_ADR   (32'h100),
        .NB_WORDS   (32),
        .BURST_LEN  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wb_m      (wb),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory slave: word i at 0x100 + 4*i holds 0xA000_0000 + i, with
    // wait_n wait states before each ack.
    int wait_n = 0;
    int wcnt   = 0;
    assign wb.ack    = wb.cyc && wb.stb && (wcnt >= wait_n);
    assign wb.dat_sm = 32'hA000_0000 + ((wb.adr - 32'h100) >> 2);
    assign wb.err    = 1'b0;
    assign wb.rty    = 1'b0;

    always @(posedge clk) begin
        if (wb.cyc && wb.stb && !wb.ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    // Model state: accepted beats and consumed words since reset.
    int          acks   = 0;
    int          pops   = 0;
    int          bursts = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] pop_data [256];
    logic        pop_sof  [256];
    logic [31:0] bus_adr  [256];
    logic [2:0]  bus_cti  [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acks        <= 0;
            pops        <= 0;
            pop_data[0] <= 32'h0;
            pop_sof[0]  <= 1'b0;
        end else begin
            if (wb.cyc && wb.stb && wb.ack) begin
                bus_adr[acks % 256] <= wb.adr;
                bus_cti[acks % 256] <= wb.cti;
                acks <= acks + 1;
            end
            if (out_valid && out_ready) begin
                pop_data[pops % 256] <= out_data;
                pop_sof[pops % 256]  <= out_sof;
                pops <= pops + 1;
            end
        end
    end

    function automatic logic [31:0] exp_word(input int k);
        return 32'hA000_0000 + 32'(k % 32);
    endfunction

    function automatic logic exp_sof(input int k);
        return (k % 32) == 0;
    endfunction

    function automatic logic [31:0] exp_adr(input int k);
        return 32'h100 + 32'(4 * (k % 32));
    endfunction

    function automatic logic [2:0] exp_cti(input int k);
        return ((k % 8) == 7) ? 3'b111 : 3'b010;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (wb.cyc && !prev_cyc) bursts <= bursts + 1;
        prev_cyc <= wb.cyc;
        if (!rst) begin
            chk("stb_vs_cyc", 32'(wb.stb), 32'(wb.cyc));
            if (wb.stb) begin
                chk("adr", wb.adr, exp_adr(acks));
                chk("cti", 32'(wb.cti), 32'(exp_cti(acks)));
                chk("static_fields", {25'b0, wb.we, wb.sel, wb.bte}, {25'b0, 1'b0, 4'hF, 2'b00});
            end else begin
                chk("cti_idle", 32'(wb.cti), 32'h0);
            end
            chk("out_valid", 32'(out_valid), 32'(acks != pops));
            if (out_valid) begin
                chk("out_data", out_data, exp_word(pops));
                chk("out_sof", 32'(out_sof), 32'(exp_sof(pops)));
            end
            chk("fifo_bound", 32'((acks - pops) <= 16), 32'h1);
        end
    end

    task automatic wait_pops(input int target, input int limit);
        int n = 0;
        while (pops < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pops", 32'(pops >= target), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        enable    = 1'b0;
        out_ready = 1'b1;
        while ((wb.cyc || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(wb.cyc || out_valid), 32'h0);
        @(negedge clk);
    endtask

    int b0;
    int p0;
    int a0;
    int n;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wb.cyc), 32'h0);
        chk("rst_stb", 32'(wb.stb), 32'h0);
        chk("rst_cti", 32'(wb.cti), 32'h0);
        chk("rst_adr", wb.adr, 32'h100);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sof", 32'(out_sof), 32'h0);
        chk("rst_data", out_data, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_without_enable", 32'(wb.cyc), 32'h0);

        // Free-running frame loop, 70 words
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_pops(70, 2000);
        chk("a_word0", pop_data[0], 32'hA000_0000);
        chk("a_sof0", 32'(pop_sof[0]), 32'h1);
        chk("a_word1_sof", 32'(pop_sof[1]), 32'h0);
        chk("a_word31", pop_data[31], 32'hA000_001F);
        chk("a_sof31", 32'(pop_sof[31]), 32'h0);
        chk("a_word32", pop_data[32], 32'hA000_0000);
        chk("a_sof32", 32'(pop_sof[32]), 32'h1);
        chk("a_adr0", bus_adr[0], 32'h100);
        chk("a_adr31", bus_adr[31], 32'h17C);
        chk("a_adr32", bus_adr[32], 32'h100);
        chk("a_cti6", 32'(bus_cti[6]), 32'h2);
        chk("a_cti7", 32'(bus_cti[7]), 32'h7);
        chk("a_cti8", 32'(bus_cti[8]), 32'h2);
        drain();

        // Backpressure: FIFO fills with exactly two bursts
        out_ready = 1'b0;
        b0 = bursts;
        enable = 1'b1;
        repeat (200) @(negedge clk);
        chk("bp_bursts", 32'(bursts - b0), 32'h2);
        chk("bp_level", 32'(acks - pops), 32'd16);
        chk("bp_cyc", 32'(wb.cyc), 32'h0);
        p0 = pops;
        out_ready = 1'b1;
        n = 0;
        while (pops - p0 < 8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        repeat (100) @(negedge clk);
        chk("bp_popped", 32'(pops - p0), 32'd8);
        chk("bp_bursts_after", 32'(bursts - b0), 32'h3);
        chk("bp_level_after", 32'(acks - pops), 32'd16);
        drain();

        // Wait states: two per beat
        wait_n = 2;
        p0 = pops;
        enable = 1'b1;
        out_ready = 1'b1;
        wait_pops(p0 + 24, 2000);
        drain();
        wait_n = 0;

        // Enable dropped at beat 3: burst completes, nothing follows
        b0 = bursts;
        a0 = acks;
        enable = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!(wb.stb && (acks - a0) == 3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        n = 0;
        while (wb.cyc && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d_beats", 32'(acks - a0), 32'd8);
        chk("d_last_cti", 32'(bus_cti[(acks - 1) % 256]), 32'h7);
        repeat (50) @(negedge clk);
        chk("d_no_more_bursts", 32'(bursts - b0), 32'h1);
        drain();

        // Asynchronous reset during beat 5 of burst 2
        b0 = bursts;
        enable = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!((bursts - b0) == 2 && wb.stb && (acks % 8) == 5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("e_reached_beat5", 32'(wb.stb && (acks % 8) == 5), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("e_cyc_drop", 32'(wb.cyc), 32'h0);
        chk("e_stb_drop", 32'(wb.stb), 32'h0);
        chk("e_valid_drop", 32'(out_valid), 32'h0);
        chk("e_adr_reset", wb.adr, 32'h100);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_pops(1, 200);
        chk("e_first_word", pop_data[0], 32'hA000_0000);
        chk("e_first_sof", 32'(pop_sof[0]), 32'h1);
        wait_pops(40, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
